// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: round-robin arbiter between I-cache and D-cache misses, registering the winner's command toward L2.
module l1_l2_arbiter #(
    parameter int width = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             icache_read,
    input  logic [31:0]      icache_address,
    output logic [width-1:0] icache_rdata,
    output logic             icache_resp,
    input  logic             dcache_read,
    input  logic             dcache_write,
    input  logic [31:0]      dcache_address,
    input  logic [width-1:0] dcache_wdata,
    input  logic [3:0]       dcache_byte_enable,
    output logic [width-1:0] dcache_rdata,
    output logic             dcache_resp,
    output logic             l2_read,
    output logic             l2_write,
    output logic [31:0]      l2_address,
    output logic [width-1:0] l2_wdata,
    output logic [3:0]       l2_byte_enable,
    output logic             l2_src,
    input  logic [width-1:0] l2_rdata,
    input  logic             l2_resp
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RECOVER} state_t;
    state_t state, state_next;
    logic last_served, last_next;
    logic read_next, write_next, src_next;
    logic [31:0] address_next;
    logic [width-1:0] wdata_next;
    logic [3:0] byte_enable_next;
    logic i_req, d_req;
    assign i_req = icache_read;
    assign d_req = dcache_read | dcache_write;
    assign icache_rdata = l2_rdata;
    assign dcache_rdata = l2_rdata;
    assign icache_resp = l2_resp & (state == GRANT_I);
    assign dcache_resp = l2_resp & (state == GRANT_D);
    always_comb begin
        state_next = state;
        last_next = last_served;
        read_next = l2_read;
        write_next = l2_write;
        address_next = l2_address;
        wdata_next = l2_wdata;
        byte_enable_next = l2_byte_enable;
        src_next = l2_src;
        case (state)
            IDLE: begin
                // last_served==1 means the D-cache went last, so a tie goes to the I-cache
                if (i_req & (~d_req | last_served)) begin
                    state_next = GRANT_I;
                    read_next = 1'b1;
                    write_next = 1'b0;
                    address_next = icache_address;
                    wdata_next = '0;
                    byte_enable_next = 4'hF;
                    src_next = 1'b0;
                end else if (d_req) begin
                    state_next = GRANT_D;
                    read_next = dcache_read & ~dcache_write;
                    write_next = dcache_write;
                    address_next = dcache_address;
                    wdata_next = dcache_wdata;
                    byte_enable_next = dcache_byte_enable;
                    src_next = 1'b1;
                end
            end
            GRANT_I, GRANT_D: begin
                if (l2_resp) begin
                    state_next = RECOVER;
                    last_next = (state == GRANT_D);
                    read_next = 1'b0;
                    write_next = 1'b0;
                    address_next = '0;
                    wdata_next = '0;
                    byte_enable_next = '0;
                    src_next = 1'b0;
                end
            end
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last_served <= 1'b1;
            l2_read <= 1'b0;
            l2_write <= 1'b0;
            l2_address <= '0;
            l2_wdata <= '0;
            l2_byte_enable <= '0;
            l2_src <= 1'b0;
        end else begin
            state <= state_next;
            last_served <= last_next;
            l2_read <= read_next;
            l2_write <= write_next;
            l2_address <= address_next;
            l2_wdata <= wdata_next;
            l2_byte_enable <= byte_enable_next;
            l2_src <= src_next;
        end
    end
endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb_l1_l2_arbiter: directed and randomized checks of l1_l2_arbiter against a transaction-level model.
module tb_l1_l2_arbiter;
    localparam int W = 256;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic icache_read = 1'b0, dcache_read = 1'b0, dcache_write = 1'b0, l2_resp = 1'b0;
    logic [31:0] icache_address = '0, dcache_address = '0;
    logic [W-1:0] dcache_wdata = '0, l2_rdata = '0;
    logic [3:0] dcache_byte_enable = '0;
    logic [W-1:0] icache_rdata, dcache_rdata, l2_wdata;
    logic icache_resp, dcache_resp, l2_read, l2_write, l2_src;
    logic [31:0] l2_address;
    logic [3:0] l2_byte_enable;

    l1_l2_arbiter #(.width(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_byte_enable(dcache_byte_enable), .dcache_rdata(dcache_rdata),
        .dcache_resp(dcache_resp), .l2_read(l2_read), .l2_write(l2_write),
        .l2_address(l2_address), .l2_wdata(l2_wdata), .l2_byte_enable(l2_byte_enable),
        .l2_src(l2_src), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    // model: owner 0=none 1=I 2=D; bubble marks the post-completion cycle
    int owner, last;
    bit bubble, auto_drop = 1'b0;
    logic e_read, e_write, e_src;
    logic [31:0] e_addr;
    logic [W-1:0] e_wdata;
    logic [3:0] e_be;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clear_exp();
        e_read = 0; e_write = 0; e_src = 0; e_addr = '0; e_wdata = '0; e_be = '0;
    endtask

    task automatic model_reset();
        owner = 0; bubble = 0; last = 2;
        clear_exp();
    endtask

    task automatic model_update();
        int pick;
        bit ri, rd;
        if (!rst_n) model_reset();
        else if (bubble) bubble = 0;
        else if (owner != 0) begin
            if (l2_resp) begin
                last = owner; owner = 0; bubble = 1;
                clear_exp();
            end
        end else begin
            ri = icache_read;
            rd = dcache_read | dcache_write;
            pick = (ri && rd) ? ((last == 2) ? 1 : 2) : ri ? 1 : rd ? 2 : 0;
            owner = pick;
            if (pick == 1) begin
                e_read = 1; e_write = 0; e_addr = icache_address; e_wdata = '0; e_be = 4'hF; e_src = 0;
            end else if (pick == 2) begin
                e_write = dcache_write; e_read = dcache_read && !dcache_write;
                e_addr = dcache_address; e_wdata = dcache_wdata; e_be = dcache_byte_enable; e_src = 1;
            end
        end
    endtask

    task automatic check_all();
        check("l2_read", 256'(l2_read), 256'(e_read));
        check("l2_write", 256'(l2_write), 256'(e_write));
        check("l2_address", 256'(l2_address), 256'(e_addr));
        check("l2_wdata", l2_wdata, e_wdata);
        check("l2_byte_enable", 256'(l2_byte_enable), 256'(e_be));
        check("l2_src", 256'(l2_src), 256'(e_src));
        check("icache_resp", 256'(icache_resp), 256'(rst_n && l2_resp && owner == 1));
        check("dcache_resp", 256'(dcache_resp), 256'(rst_n && l2_resp && owner == 2));
        check("icache_rdata", icache_rdata, l2_rdata);
        check("dcache_rdata", dcache_rdata, l2_rdata);
    endtask

    task automatic cyc();
        bit idn, ddn;
        #1 check_all();
        idn = rst_n && l2_resp && owner == 1;
        ddn = rst_n && l2_resp && owner == 2;
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (auto_drop && idn) icache_read = 0;
        if (auto_drop && ddn) begin dcache_read = 0; dcache_write = 0; end
    endtask

    initial begin
        bit ps;
        int since, r;
        bit cur;
        model_reset();
        @(negedge clk);
        cyc(); cyc();
        rst_n = 1;
        cyc();
        // single I-cache read, response in cycle 5
        icache_read = 1; icache_address = 32'h0000_1000;
        cyc();
        check("i_read_c1", 256'(l2_read), 256'(1));
        check("i_addr_c1", 256'(l2_address), 256'(32'h1000));
        check("i_be_c1", 256'(l2_byte_enable), 256'(4'hF));
        repeat (4) cyc();
        l2_resp = 1; l2_rdata = {32{8'hA5}};
        #1 check("i_resp_c5", 256'({icache_resp, dcache_resp}), 256'(2'b10));
        check("i_rdata_c5", icache_rdata, {32{8'hA5}});
        cyc();
        icache_read = 0; l2_resp = 0;
        #1 check("zero_c6", 256'({l2_read, l2_write, l2_address, l2_byte_enable, l2_src}), 256'(0));
        cyc(); cyc();
        // contention: both hold requests, grants alternate starting with D
        icache_read = 1; dcache_read = 1; dcache_address = 32'h0000_3000;
        ps = 0; since = 0;
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 8 && !(l2_read || l2_write); k++) begin cyc(); since++; end
            cur = !ps;
            check("cont_grant", 256'(l2_read | l2_write), 256'(1));
            check("cont_src", 256'(l2_src), 256'(cur));
            if (g > 0) check("cont_gap", 256'(since), 256'(3));
            cyc(); cyc();
            l2_resp = 1;
            #1 check("cont_resp", 256'({icache_resp, dcache_resp}), cur ? 256'(2'b01) : 256'(2'b10));
            ps = cur;
            cyc();
            l2_resp = 0; since = 1;
        end
        icache_read = 0; dcache_read = 0;
        cyc(); cyc();
        // D-cache writeback, address change while granted is ignored
        dcache_write = 1; dcache_address = 32'h0000_2000;
        dcache_wdata = {8{32'h1234_5678}}; dcache_byte_enable = 4'b0011;
        cyc();
        check("wb_write", 256'({l2_write, l2_read}), 256'(2'b10));
        check("wb_wdata", l2_wdata, {8{32'h1234_5678}});
        check("wb_be", 256'(l2_byte_enable), 256'(4'b0011));
        dcache_address = 32'hDEAD_0000;
        cyc();
        check("wb_addr_hold", 256'(l2_address), 256'(32'h2000));
        l2_resp = 1;
        #1 check("wb_resp", 256'({icache_resp, dcache_resp}), 256'(2'b01));
        cyc();
        dcache_write = 0;
        #1 check("spur_recover", 256'({icache_resp, dcache_resp}), 256'(0));
        cyc();
        #1 check("spur_idle", 256'({icache_resp, dcache_resp}), 256'(0));
        cyc();
        l2_resp = 0;
        cyc();
        // read+write together: write wins; then reset mid-grant
        dcache_read = 1; dcache_write = 1;
        cyc();
        check("rw_write_wins", 256'({l2_write, l2_read}), 256'(2'b10));
        #2 rst_n = 0; l2_resp = 1;
        #1 check("rst_l2_zero", 256'({l2_read, l2_write, l2_address, l2_byte_enable, l2_src}), 256'(0));
        check("rst_wdata", l2_wdata, 256'(0));
        check("rst_resp", 256'({icache_resp, dcache_resp}), 256'(0));
        model_reset();
        icache_read = 1; l2_resp = 0;
        @(negedge clk);
        rst_n = 1;
        cyc();
        check("rst_tie_i", 256'({l2_src, l2_read}), 256'(2'b01));
        // randomized traffic
        auto_drop = 1;
        repeat (400) begin
            if (!icache_read && $urandom % 3 == 0) icache_read = 1;
            if (!dcache_read && !dcache_write && $urandom % 3 == 0) begin
                r = $urandom % 3;
                dcache_read = (r != 1);
                dcache_write = (r != 0);
            end
            icache_address = $urandom;
            dcache_address = $urandom;
            dcache_byte_enable = 4'($urandom);
            for (int j = 0; j < 8; j++) begin
                dcache_wdata[j*32 +: 32] = $urandom;
                l2_rdata[j*32 +: 32] = $urandom;
            end
            l2_resp = ($urandom % 4 == 0);
            cyc();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
